// File: rtl/seq110_pkg.sv
// Shared types for the multi-channel "110" sequence detector/arbiter.
package seq110_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } ctx_t;

endpackage

// File: rtl/seq110_arbiter_if.sv
// Request/grant and match bus between serial channel sources and seq110_arbiter.
interface seq110_arbiter_if #(
  parameter int unsigned NCH = 4
) ();

  logic [NCH-1:0]         req_valid;
  logic [NCH-1:0]         req_bit;
  logic [NCH-1:0]         req_ready;
  logic                   match_valid;
  logic [$clog2(NCH)-1:0] match_ch;

  modport master (
    output req_valid,
    output req_bit,
    input  req_ready,
    input  match_valid,
    input  match_ch
  );

  modport slave (
    input  req_valid,
    input  req_bit,
    output req_ready,
    output match_valid,
    output match_ch
  );

endinterface

// File: rtl/seq110_next.sv
// Next-state function of the "110" Moore context; shared by all channels.
module seq110_next
  import seq110_pkg::*;
(
  input  ctx_t ctx,
  input  logic data_bit,
  output ctx_t ctx_next,
  output logic is_match
);

  always_comb begin
    ctx_next = S0;
    unique case (ctx)
      S0: ctx_next = data_bit ? S1 : S0;
      S1: ctx_next = data_bit ? S2 : S0;
      S2: ctx_next = data_bit ? S2 : S3;
      S3: ctx_next = data_bit ? S1 : S0;
    endcase
    is_match = (ctx_next == S3);
  end

endmodule

// File: rtl/seq110_arbiter.sv
// Round-robin arbiter feeding NCH serial channels through one shared "110" detector,
// with per-channel saturating match counters.
module seq110_arbiter
  import seq110_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NCH-1:0]         flush,
  input  logic                   clr_cnt,
  input  logic [$clog2(NCH)-1:0] cnt_sel,
  output logic [CNT_W-1:0]       cnt_val,
  seq110_arbiter_if.slave        bus
);

  localparam int unsigned SEL_W = $clog2(NCH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctx_t             ctx_q [NCH];
  ctx_t             ctx_d [NCH];
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             match_valid_q, match_valid_d;
  logic [SEL_W-1:0] match_ch_q, match_ch_d;

  logic [NCH-1:0]   eligible;
  logic [NCH-1:0]   grant;
  logic             grant_any;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W:0]   scan_sum;
  logic [SEL_W-1:0] scan_idx;

  ctx_t             cur_ctx, nxt_ctx;
  logic             cur_bit, nxt_match;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        ctx_q[i] <= S0;
        cnt_q[i] <= '0;
      end
      rr_ptr_q      <= '0;
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
    end else begin
      ctx_q         <= ctx_d;
      cnt_q         <= cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      match_valid_q <= match_valid_d;
      match_ch_q    <= match_ch_d;
    end
  end

  // Grant: first eligible channel scanning upward from rr_ptr, wrapping at NCH.
  always_comb begin
    eligible  = bus.req_valid & ~flush & {NCH{enable & ~reset}};
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (SEL_W + 1)'(k);
      if (scan_sum >= (SEL_W + 1)'(NCH)) begin
        scan_sum = scan_sum - (SEL_W + 1)'(NCH);
      end
      scan_idx = scan_sum[SEL_W-1:0];
      if (!grant_any && eligible[scan_idx]) begin
        grant_any       = 1'b1;
        grant_idx       = scan_idx;
        grant[scan_idx] = 1'b1;
      end
    end
  end

  assign cur_ctx = ctx_q[grant_idx];
  assign cur_bit = bus.req_bit[grant_idx];

  seq110_next u_next (
    .ctx      (cur_ctx),
    .data_bit (cur_bit),
    .ctx_next (nxt_ctx),
    .is_match (nxt_match)
  );

  // Next-state
  always_comb begin
    ctx_d         = ctx_q;
    cnt_d         = cnt_q;
    rr_ptr_d      = rr_ptr_q;
    match_valid_d = 1'b0;
    match_ch_d    = '0;
    if (grant_any) begin
      ctx_d[grant_idx] = nxt_ctx;
      rr_ptr_d = (grant_idx == SEL_W'(NCH - 1)) ? '0 : grant_idx + SEL_W'(1);
      if (nxt_match) begin
        match_valid_d = 1'b1;
        match_ch_d    = grant_idx;
        if (cnt_q[grant_idx] != CNT_MAX) begin
          cnt_d[grant_idx] = cnt_q[grant_idx] + CNT_W'(1);
        end
      end
    end
    // A flushed channel is never granted, so this cannot collide with the update above.
    for (int i = 0; i < NCH; i++) begin
      if (flush[i]) ctx_d[i] = S0;
    end
    if (clr_cnt) begin
      for (int i = 0; i < NCH; i++) cnt_d[i] = '0;
    end
  end

  // Outputs
  always_comb begin
    bus.req_ready   = grant;
    bus.match_valid = match_valid_q;
    bus.match_ch    = match_ch_q;
    cnt_val         = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cnt_sel == SEL_W'(i)) cnt_val = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_seq110_arbiter.sv
// Directed self-checking bench for seq110_arbiter (NCH=4; a CNT_W=2 copy for saturation).
module tb_seq110_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] flush;
  logic       clr_cnt;
  logic       clr2;
  logic [1:0] cnt_sel;
  logic [1:0] cnt_sel2;
  logic [7:0] cnt_val;
  logic [1:0] cnt_val2;

  int checks = 0;
  int errors = 0;

  seq110_arbiter_if #(.NCH(4)) bus ();
  seq110_arbiter_if #(.NCH(4)) bus2 ();

  seq110_arbiter #(.NCH(4), .CNT_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .flush   (flush),
    .clr_cnt (clr_cnt),
    .cnt_sel (cnt_sel),
    .cnt_val (cnt_val),
    .bus     (bus)
  );

  seq110_arbiter #(.NCH(4), .CNT_W(2)) dut_sat (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .flush   (4'b0000),
    .clr_cnt (clr2),
    .cnt_sel (cnt_sel2),
    .cnt_val (cnt_val2),
    .bus     (bus2)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    enable = 1'b1;
    flush = '0;
    clr_cnt = 1'b0;
    clr2 = 1'b0;
    bus.req_valid = '0;
    bus.req_bit = '0;
    bus2.req_valid = '0;
    bus2.req_bit = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    enable = 1'b1;
    clr_cnt = 1'b0;
    flush = '0;
    bus.req_valid = 4'hF;
    bus.req_bit = 4'hF;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready got %b want 0000", bus.req_ready);
    end
    step();
    checks++;
    if (bus.match_valid !== 1'b0 || bus.match_ch !== 2'd0) begin
      errors++;
      $display("FAIL reset_match got %b/%0d want 0/0", bus.match_valid, bus.match_ch);
    end
    reset = 1'b0;
    bus.req_valid = 4'b0000;
    cnt_sel = 2'd0;
    #1;
    checks++;
    if (cnt_val !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d want 0", cnt_val);
    end
    bus.req_valid = 4'b0100;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL grant_single got %b want 0100", bus.req_ready);
    end
    bus.req_valid = 4'b1010;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL grant_lowest got %b want 0010", bus.req_ready);
    end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_single;
    logic [2:0] bits;
    bits = 3'b011;  // bit i is sent in cycle i: 1,1,0
    do_reset();
    cnt_sel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 4'b0001;
      bus.req_bit = {3'b000, bits[i]};
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) begin
        errors++;
        $display("FAIL single_ready[%0d] got %b want 0001", i, bus.req_ready);
      end
      step();
      checks++;
      if (bus.match_valid !== (i == 2)) begin
        errors++;
        $display("FAIL single_match[%0d] got %b want %b", i, bus.match_valid, (i == 2));
      end
    end
    checks++;
    if (bus.match_ch !== 2'd0 || cnt_val !== 8'd1) begin
      errors++;
      $display("FAIL single_ch_cnt got %0d/%0d want 0/1", bus.match_ch, cnt_val);
    end
    bus.req_valid = '0;
    step();
    checks++;
    if (bus.match_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse got %b want 0", bus.match_valid);
    end
  endtask

  task automatic test_contention;
    int nb [4];
    logic [3:0] b;
    logic [3:0] exp_r;
    logic exp_m;
    do_reset();
    for (int c = 0; c < 4; c++) nb[c] = 0;
    for (int t = 0; t <= 13; t++) begin
      if (t > 0) begin
        exp_m = (t - 1 >= 8) && (t - 1 <= 11);
        checks++;
        if (bus.match_valid !== exp_m) begin
          errors++;
          $display("FAIL cont_match[t=%0d] got %b want %b", t, bus.match_valid, exp_m);
        end
        if (exp_m) begin
          checks++;
          if (bus.match_ch !== 2'(t - 9)) begin
            errors++;
            $display("FAIL cont_ch[t=%0d] got %0d want %0d", t, bus.match_ch, t - 9);
          end
        end
      end
      if (t <= 12) begin
        for (int c = 0; c < 4; c++) b[c] = (nb[c] % 3 != 2);
        bus.req_valid = 4'hF;
        bus.req_bit = b;
        #1;
        exp_r = 4'b0001 << (t % 4);
        checks++;
        if (bus.req_ready !== exp_r) begin
          errors++;
          $display("FAIL cont_grant[t=%0d] got %b want %b", t, bus.req_ready, exp_r);
        end
        nb[t % 4]++;
        step();
      end else begin
        bus.req_valid = '0;
      end
    end
    cnt_sel = 2'd3;
    #1;
    checks++;
    if (cnt_val !== 8'd1) begin
      errors++;
      $display("FAIL cont_cnt3 got %0d want 1", cnt_val);
    end
  endtask

  task automatic test_overlap;
    logic [5:0] bits;
    bits = 6'b011011;  // 1,1,0,1,1,0 from bit 0
    do_reset();
    cnt_sel = 2'd1;
    for (int i = 0; i < 6; i++) begin
      bus.req_valid = 4'b0010;
      bus.req_bit = {2'b00, bits[i], 1'b0};
      #1;
      checks++;
      if (bus.req_ready !== 4'b0010) begin
        errors++;
        $display("FAIL ovl_ready[%0d] got %b want 0010", i, bus.req_ready);
      end
      step();
      checks++;
      if (bus.match_valid !== (i == 2 || i == 5)) begin
        errors++;
        $display("FAIL ovl_match[%0d] got %b want %b", i, bus.match_valid, (i == 2 || i == 5));
      end
    end
    bus.req_valid = '0;
    checks++;
    if (cnt_val !== 8'd2) begin
      errors++;
      $display("FAIL ovl_cnt got %0d want 2", cnt_val);
    end
  endtask

  task automatic test_flush;
    do_reset();
    cnt_sel = 2'd2;
    for (int i = 0; i < 2; i++) begin
      bus.req_valid = 4'b0100;
      bus.req_bit = 4'b0100;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0100) begin
        errors++;
        $display("FAIL flush_pre[%0d] got %b want 0100", i, bus.req_ready);
      end
      step();
    end
    flush = 4'b0100;
    bus.req_valid = 4'b0100;
    bus.req_bit = 4'b0000;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL flush_block got %b want 0000", bus.req_ready);
    end
    step();
    bus.req_valid = 4'b1100;
    #1;
    checks++;
    if (bus.req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL flush_other got %b want 1000", bus.req_ready);
    end
    step();
    checks++;
    if (bus.match_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_m1 got %b want 0", bus.match_valid);
    end
    flush = 4'b0000;
    bus.req_valid = 4'b0100;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL flush_post got %b want 0100", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    checks++;
    if (bus.match_valid !== 1'b0 || cnt_val !== 8'd0) begin
      errors++;
      $display("FAIL flush_nomatch got %b/%0d want 0/0", bus.match_valid, cnt_val);
    end
  endtask

  task automatic test_saturation;
    logic [1:0] exp_c;
    do_reset();
    cnt_sel2 = 2'd0;
    for (int m = 1; m <= 5; m++) begin
      for (int i = 0; i < 3; i++) begin
        bus2.req_valid = 4'b0001;
        bus2.req_bit = {3'b000, (i != 2)};
        step();
      end
      exp_c = (m < 3) ? 2'(m) : 2'd3;
      checks++;
      if (bus2.match_valid !== 1'b1 || cnt_val2 !== exp_c) begin
        errors++;
        $display("FAIL sat_cnt[m=%0d] got %b/%0d want 1/%0d", m, bus2.match_valid, cnt_val2, exp_c);
      end
    end
    bus2.req_bit = 4'b0001;
    step();
    step();
    bus2.req_bit = 4'b0000;
    clr2 = 1'b1;
    step();
    clr2 = 1'b0;
    bus2.req_valid = '0;
    checks++;
    if (bus2.match_valid !== 1'b1 || cnt_val2 !== 2'd0) begin
      errors++;
      $display("FAIL sat_clear got %b/%0d want 1/0", bus2.match_valid, cnt_val2);
    end
  endtask

  task automatic test_enable;
    do_reset();
    cnt_sel = 2'd0;
    bus.req_valid = 4'b0001;
    bus.req_bit = 4'b0001;
    step();
    step();
    enable = 1'b0;
    bus.req_bit = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL en_ready[%0d] got %b want 0000", i, bus.req_ready);
      end
      step();
      checks++;
      if (bus.match_valid !== 1'b0) begin
        errors++;
        $display("FAIL en_match[%0d] got %b want 0", i, bus.match_valid);
      end
    end
    enable = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL en_resume got %b want 0001", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    checks++;
    if (bus.match_valid !== 1'b1 || bus.match_ch !== 2'd0 || cnt_val !== 8'd1) begin
      errors++;
      $display("FAIL en_final got %b/%0d/%0d want 1/0/1", bus.match_valid, bus.match_ch, cnt_val);
    end
    enable = 1'b0;
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    enable = 1'b1;
    checks++;
    if (cnt_val !== 8'd0) begin
      errors++;
      $display("FAIL en_clr got %0d want 0", cnt_val);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_bit = 4'b0001;
    step();
    step();
    reset = 1'b1;
    bus.req_bit = 4'b0000;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_ready got %b want 0000", bus.req_ready);
    end
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_mid_grant got %b want 0001", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    checks++;
    if (bus.match_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_nomatch got %b want 0", bus.match_valid);
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    flush = '0;
    clr_cnt = 1'b0;
    clr2 = 1'b0;
    cnt_sel = '0;
    cnt_sel2 = '0;
    bus.req_valid = '0;
    bus.req_bit = '0;
    bus2.req_valid = '0;
    bus2.req_bit = '0;
    step();
    step();
    test_reset();
    test_single();
    test_contention();
    test_overlap();
    test_flush();
    test_saturation();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq110_arbiter.md
SEQ110_ARBITER -- requirements
Module: seq110_arbiter

Interface
REQ-001 Parameter NCH, default 4: number of serial input channels sharing one 110 detector (2..8).
REQ-002 Parameter CNT_W, default 8: width of each per-channel match counter.
REQ-003 Clock clk SHALL be the only clock; reset reset, synchronous, active-high; clock clk.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 enable  input  1  1 = arbitration and detection active; 0 = frozen.
REQ-007 req_valid  input  NCH  per-channel serial bit available.
REQ-008 req_bit  input  NCH  per-channel serial data bit.
REQ-009 req_ready  output  NCH  one-hot grant; a bit transfers when req_valid[i] & req_ready[i].
REQ-010 flush  input  NCH  per-channel detector-context clear.
REQ-011 clr_cnt  input  1  clear all match counters.
REQ-012 match_valid  output  1  one-cycle pulse: a channel completed "110".
REQ-013 match_ch  output  clog2(NCH)  channel index qualifying match_valid.
REQ-014 cnt_sel  input  clog2(NCH)  counter readback select.
REQ-015 cnt_val  output  CNT_W  counter value of channel cnt_sel, combinational.

Function
REQ-016 The block SHALL keep a 2-bit Moore context ctx[i] per channel: S0 idle, S1 seen "1", S2 seen "11", S3 seen "110".
REQ-017 Transitions on an accepted bit b SHALL be: S0: b=1->S1, b=0->S0; S1: 1->S2, 0->S0; S2: 1->S2, 0->S3; S3: 1->S1, 0->S0.
REQ-018 Arbitration SHALL be round-robin: grant the lowest index >= rr_ptr (wrapping modulo NCH) with req_valid=1, enable=1 and flush=0.
REQ-019 At most one req_ready bit SHALL be high per cycle; req_ready SHALL be combinational from req_valid, flush, enable and rr_ptr.
REQ-020 After a transfer on channel g, rr_ptr SHALL become (g+1) mod NCH; with no transfer rr_ptr SHALL hold.
REQ-021 Only the granted channel's ctx SHALL update; all other contexts hold.
REQ-022 match_valid SHALL be registered: high in the cycle after a transfer whose next state is S3, with match_ch = g; otherwise low.
REQ-023 Overlap: after S3, a '1' SHALL go to S1, so "1101 10" yields two matches.
REQ-024 On each match, cnt[g] SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-025 clr_cnt=1 SHALL zero all counters next cycle; clear wins over a simultaneous increment.
REQ-026 flush[i]=1 SHALL set ctx[i] to S0 next cycle and block its grant that cycle; other channels are unaffected and may be granted.
REQ-027 enable=0 SHALL force req_ready=0 and match_valid=0 next cycle, and hold ctx, counters and rr_ptr; flush and clr_cnt still act.
REQ-028 Latency from the accepted '0' of "110" to match_valid SHALL be exactly 1 cycle.

Reset
REQ-029 On reset: all ctx = S0, rr_ptr = 0, all counters = 0, match_valid = 0, match_ch = 0.
REQ-030 Reset SHALL override flush, clr_cnt and any transfer in the same cycle; req_ready SHALL be 0 during reset.
REQ-031 Reset mid-sequence SHALL discard partial matches: after reset, "0" alone SHALL NOT produce a match.

Structure
REQ-032 State encodings S0..S3 (2'b00..2'b11) SHALL live in shared package seq110_pkg with a ctx_t typedef.
REQ-033 The next-state function SHALL be a sub-module seq110_next (inputs: ctx, bit; outputs: next ctx, is_match), instantiated once and shared by all channels.
REQ-034 The round-robin grant logic SHALL remain inside seq110_arbiter.

Verification
REQ-035 Single channel: ch0 valid with bits 1,1,0 over 3 cycles -> match_valid=1, match_ch=0 one cycle after the third transfer; cnt_val(sel 0)=1.
REQ-036 Contention: all 4 valid every cycle -> grants 0,1,2,3,0,...; each channel streaming 1,1,0 -> matches on ch0..ch3 in consecutive cycles 9..12 after the first grant.
REQ-037 Overlap: ch1 sends 1,1,0,1,1,0 -> two matches; cnt[1]=2.
REQ-038 Flush: ch2 sends 1,1, then flush[2]=1 for one cycle, then 0 -> no match; ch3 is granted in the flush cycle if valid.
REQ-039 Saturation and clear: CNT_W=2, ch0 produces 5 matches -> cnt=3; clr_cnt coincident with a 6th match -> cnt=0.
REQ-040 Reset/enable: ch0 at S2, enable=0 for 3 cycles with valid high -> req_ready=0, then enable=1 and bit 0 -> match; repeat with reset instead of enable -> no match.
